// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI-attached RAM controller: command opcodes,
// controller FSM states and the opcode field width.
package spi_ram_pkg;

    // Width of the opcode field that sits above the payload in each word
    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_WADDR = 2'b00,
        OP_WDATA = 2'b01,
        OP_RADDR = 2'b10,
        OP_RDATA = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_WR_ARMED = 2'b01,
        ST_RD_ARMED = 2'b10
    } state_t;

endpackage

// File: rtl/spi_ram_array.sv
// MEM_DEPTH x DATA_W single-port storage with a synchronous write port and a
// registered read port. The read register holds its value between reads.
module spi_ram_array #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // Storage write; commits on the edge where we is sampled high
    // NOTE: the array has no reset branch so it maps onto plain RAM cells;
    // contents are undefined until written and survive rst_n.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register: loads only on a read, so it doubles as the held output
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of its inputs regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command-decoded RAM controller behind the SPI slave. Decodes opcode+payload
// words, keeps separate write/read pointers with range checking, sequences
// address/data commands through a small FSM, and reports results with
// one-cycle tx_valid / err pulses.
// Optional feature macro: SPI_RAM_AUTO_INC_EN -- when defined, accepted data
// commands post-increment their pointer (wrapping at MEM_DEPTH-1) and keep the
// FSM armed for bursts; otherwise each data command returns the FSM to IDLE.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_W+OP_W-1:0] din,
    input  logic                 rx_valid,
    output logic [DATA_W-1:0]    dout,
    output logic                 tx_valid,
    output logic                 err,
    output logic [1:0]           state_o
);

    // Depth limit widened by one bit so MEM_DEPTH == 2**ADDR_W still compares
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);
`ifdef SPI_RAM_AUTO_INC_EN
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(MEM_DEPTH - 1);
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic              err_d;
    logic              we, re;
    logic              tx_valid_q, err_q;

    op_t               opcode;
    logic [DATA_W-1:0] payload;
    logic [ADDR_W-1:0] addr;
    logic              in_range;

    assign opcode   = op_t'(din[DATA_W+OP_W-1:DATA_W]);
    assign payload  = din[DATA_W-1:0];
    assign addr     = payload[ADDR_W-1:0];
    assign in_range = ({1'b0, addr} < DEPTH_LIM);

    // Command decode: next state, pointer updates, memory strobes, error
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        we       = 1'b0;
        re       = 1'b0;
        err_d    = 1'b0;
        if (rx_valid) begin
            case (opcode)
                OP_WADDR: begin
                    if (in_range) begin
                        wr_ptr_d = addr;
                        state_d  = ST_WR_ARMED;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_RADDR: begin
                    if (in_range) begin
                        rd_ptr_d = addr;
                        state_d  = ST_RD_ARMED;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_WDATA: begin
                    if (state_q == ST_WR_ARMED) begin
                        we = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
                        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_RDATA: begin
                    if (state_q == ST_RD_ARMED) begin
                        re = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
                        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    // FSM state, pointers and the one-cycle result pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tx_valid_q <= re;
            err_q      <= err_d;
        end
    end

    spi_ram_array #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata (payload),
        .re    (re),
        .raddr (rd_ptr_q),
        .rdata (dout)
    );

    assign tx_valid = tx_valid_q;
    assign err      = err_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl. Two instances share the command stream:
// dut (MEM_DEPTH 256) and dut200 (MEM_DEPTH 200) for the range-limit checks.
// Burst expectations follow SPI_RAM_AUTO_INC_EN.
module tb_spi_ram_ctrl;
    import spi_ram_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] din = '0;
    logic       rx_valid = 1'b0;

    logic [7:0] dout,  dout2;
    logic       tx,    tx2;
    logic       er,    er2;
    logic [1:0] st,    st2;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    spi_ram_ctrl #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout), .tx_valid(tx), .err(er), .state_o(st)
    );

    spi_ram_ctrl #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200)) dut200 (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout2), .tx_valid(tx2), .err(er2), .state_o(st2)
    );

    // One command per cycle; returns 1 time unit after the sampling edge
    task automatic cmd(input logic [1:0] op, input logic [7:0] pl);
        @(negedge clk);
        din      = {op, pl};
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (dout !== 8'h00) $display("FAIL reset_dout got %h exp 00", dout); else passes++;
        checks++; if (tx !== 1'b0) $display("FAIL reset_tx got %b exp 0", tx); else passes++;
        checks++; if (er !== 1'b0) $display("FAIL reset_err got %b exp 0", er); else passes++;
        checks++; if (st !== ST_IDLE) $display("FAIL reset_state got %b exp 00", st); else passes++;
        checks++; if (st2 !== ST_IDLE) $display("FAIL reset_state200 got %b exp 00", st2); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_err_after_reset();
        do_reset();
        cmd(OP_WADDR, 8'h00);
        cmd(OP_WDATA, 8'h3C);
        do_reset();
        cmd(OP_RDATA, 8'h00);
        checks++; if (er !== 1'b1) $display("FAIL rdata_after_reset_err got %b exp 1", er); else passes++;
        checks++; if (tx !== 1'b0) $display("FAIL rdata_after_reset_tx got %b exp 0", tx); else passes++;
        checks++; if (dout !== 8'h00) $display("FAIL rdata_after_reset_dout got %h exp 00", dout); else passes++;
        checks++; if (st !== ST_IDLE) $display("FAIL rdata_after_reset_state got %b exp 00", st); else passes++;
        cmd(OP_WDATA, 8'h77);
        checks++; if (er !== 1'b1) $display("FAIL wdata_after_reset_err got %b exp 1", er); else passes++;
        cmd(OP_RADDR, 8'h00);
        checks++; if (er !== 1'b0) $display("FAIL raddr0_err got %b exp 0", er); else passes++;
        checks++; if (st !== ST_RD_ARMED) $display("FAIL raddr0_state got %b exp 10", st); else passes++;
        cmd(OP_RDATA, 8'h00);
        checks++; if (tx !== 1'b1) $display("FAIL mem_kept_tx got %b exp 1", tx); else passes++;
        checks++; if (dout !== 8'h3C) $display("FAIL mem_kept_dout got %h exp 3c", dout); else passes++;
        idle();
    endtask

    task automatic test_basic();
        do_reset();
        cmd(OP_WADDR, 8'h10);
        checks++; if (st !== ST_WR_ARMED || er !== 1'b0) $display("FAIL basic_waddr got st=%b err=%b exp st=01 err=0", st, er); else passes++;
        cmd(OP_WDATA, 8'hA5);
`ifdef SPI_RAM_AUTO_INC_EN
        checks++; if (st !== ST_WR_ARMED) $display("FAIL basic_wdata_state got %b exp 01", st); else passes++;
`else
        checks++; if (st !== ST_IDLE) $display("FAIL basic_wdata_state got %b exp 00", st); else passes++;
`endif
        checks++; if (er !== 1'b0 || tx !== 1'b0) $display("FAIL basic_wdata_pulses got err=%b tx=%b exp 0 0", er, tx); else passes++;
        cmd(OP_RADDR, 8'h10);
        checks++; if (st !== ST_RD_ARMED || er !== 1'b0) $display("FAIL basic_raddr got st=%b err=%b exp st=10 err=0", st, er); else passes++;
        cmd(OP_RDATA, 8'h00);
        checks++; if (tx !== 1'b1) $display("FAIL basic_tx got %b exp 1", tx); else passes++;
        checks++; if (dout !== 8'hA5) $display("FAIL basic_dout got %h exp a5", dout); else passes++;
        checks++; if (er !== 1'b0) $display("FAIL basic_err got %b exp 0", er); else passes++;
        idle();
        checks++; if (tx !== 1'b0) $display("FAIL basic_tx_one_cycle got %b exp 0", tx); else passes++;
        checks++; if (dout !== 8'hA5) $display("FAIL basic_dout_hold got %h exp a5", dout); else passes++;
    endtask

`ifdef SPI_RAM_AUTO_INC_EN
    task automatic test_burst();
        logic [7:0] exp_data [3];
        exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h33;
        do_reset();
        cmd(OP_WADDR, 8'hFE);
        for (int i = 0; i < 3; i++) begin
            cmd(OP_WDATA, exp_data[i]);
            checks++; if (er !== 1'b0 || st !== ST_WR_ARMED) $display("FAIL burst_wdata%0d got err=%b st=%b exp 0 01", i, er, st); else passes++;
        end
        cmd(OP_RADDR, 8'hFE);
        for (int i = 0; i < 3; i++) begin
            cmd(OP_RDATA, 8'h00);
            checks++; if (tx !== 1'b1 || dout !== exp_data[i]) $display("FAIL burst_rdata%0d got tx=%b dout=%h exp 1 %h", i, tx, dout, exp_data[i]); else passes++;
        end
        cmd(OP_RADDR, 8'h00);
        cmd(OP_RDATA, 8'h00);
        checks++; if (dout !== 8'h33) $display("FAIL burst_wrap_mem0 got %h exp 33", dout); else passes++;
        idle();
    endtask
`else
    task automatic test_single_access();
        do_reset();
        cmd(OP_WADDR, 8'h05);
        cmd(OP_WDATA, 8'h01);
        checks++; if (er !== 1'b0 || st !== ST_IDLE) $display("FAIL single_wdata1 got err=%b st=%b exp 0 00", er, st); else passes++;
        cmd(OP_WDATA, 8'h02);
        checks++; if (er !== 1'b1) $display("FAIL single_wdata2_err got %b exp 1", er); else passes++;
        cmd(OP_RADDR, 8'h05);
        cmd(OP_RDATA, 8'h00);
        checks++; if (tx !== 1'b1 || dout !== 8'h01) $display("FAIL single_mem5 got tx=%b dout=%h exp 1 01", tx, dout); else passes++;
        cmd(OP_RDATA, 8'h00);
        checks++; if (er !== 1'b1 || tx !== 1'b0 || dout !== 8'h01) $display("FAIL single_rdata2 got err=%b tx=%b dout=%h exp 1 0 01", er, tx, dout); else passes++;
        idle();
    endtask
`endif

    task automatic test_range();
        do_reset();
        cmd(OP_WADDR, 8'h10);
        cmd(OP_WADDR, 8'hC8);
        checks++; if (er2 !== 1'b1) $display("FAIL range200_c8_err got %b exp 1", er2); else passes++;
        checks++; if (st2 !== ST_WR_ARMED) $display("FAIL range200_c8_state got %b exp 01", st2); else passes++;
        checks++; if (er !== 1'b0) $display("FAIL range256_c8_err got %b exp 0", er); else passes++;
        cmd(OP_WDATA, 8'h5A);
        checks++; if (er2 !== 1'b0) $display("FAIL range200_wdata_err got %b exp 0", er2); else passes++;
        cmd(OP_WADDR, 8'hC7);
        checks++; if (er2 !== 1'b0 || st2 !== ST_WR_ARMED) $display("FAIL range200_c7 got err=%b st=%b exp 0 01", er2, st2); else passes++;
        cmd(OP_RADDR, 8'h10);
        cmd(OP_RDATA, 8'h00);
        checks++; if (tx2 !== 1'b1 || dout2 !== 8'h5A) $display("FAIL range200_wrptr_kept got tx=%b dout=%h exp 1 5a", tx2, dout2); else passes++;
        cmd(OP_RADDR, 8'hC8);
        checks++; if (er2 !== 1'b1) $display("FAIL range200_raddr_c8_err got %b exp 1", er2); else passes++;
`ifdef SPI_RAM_AUTO_INC_EN
        checks++; if (st2 !== ST_RD_ARMED) $display("FAIL range200_raddr_state got %b exp 10", st2); else passes++;
`else
        checks++; if (st2 !== ST_IDLE) $display("FAIL range200_raddr_state got %b exp 00", st2); else passes++;
`endif
        idle();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        cmd(OP_WADDR, 8'h30);
        cmd(OP_WDATA, 8'h99);
        cmd(OP_RADDR, 8'h30);
        cmd(OP_RDATA, 8'h00);
        checks++; if (tx !== 1'b1 || dout !== 8'h99) $display("FAIL midrst_pre got tx=%b dout=%h exp 1 99", tx, dout); else passes++;
        #2;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        #1;
        checks++; if (tx !== 1'b0) $display("FAIL midrst_tx got %b exp 0", tx); else passes++;
        checks++; if (dout !== 8'h00) $display("FAIL midrst_dout got %h exp 00", dout); else passes++;
        checks++; if (st !== ST_IDLE) $display("FAIL midrst_state got %b exp 00", st); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        cmd(OP_RDATA, 8'h00);
        checks++; if (er !== 1'b1 || tx !== 1'b0) $display("FAIL midrst_rdata_after got err=%b tx=%b exp 1 0", er, tx); else passes++;
        idle();
    endtask

    // Guard against a stuck simulation
    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_err_after_reset();
        test_basic();
`ifdef SPI_RAM_AUTO_INC_EN
        test_burst();
`else
        test_single_access();
`endif
        test_range();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
